// File: rtl/march_controller.sv
// March C- sequencing FSM for memory BIST. Drives an external address
// generator and a synchronous RAM, checks read data against the expected
// background and records the first failing address/element.
module march_controller #(
    parameter int unsigned a_width      = 4,
    parameter int unsigned d_width      = 8,
    parameter bit          stop_on_fail = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               gen_reset_o,
    output logic               gen_preset_o,
    output logic               gen_en_o,
    output logic               gen_up_down_o,
    input  logic               gen_carry_i,
    input  logic [a_width-1:0] gen_address_i,
    output logic               mem_we_o,
    output logic               mem_re_o,
    output logic [d_width-1:0] mem_wdata_o,
    input  logic [d_width-1:0] mem_rdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    output logic [a_width-1:0] fail_addr_o,
    output logic [2:0]         fail_elem_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RD, S_CHK, S_WR, S_NEXT, S_DONE
    } state_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;

    // Elements 3 and 4 walk the address space downwards, all others upwards.
    function automatic logic elem_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Every element except the initial background write starts with a read.
    function automatic logic elem_has_read(input logic [2:0] e);
        return e != 3'd0;
    endfunction

    // Every element except the final verify pass ends with a write.
    function automatic logic elem_has_write(input logic [2:0] e);
        return e != LAST_ELEM;
    endfunction

    // w1 in elements 1 and 3, w0 everywhere else.
    function automatic logic [d_width-1:0] write_value(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? {d_width{1'b1}} : {d_width{1'b0}};
    endfunction

    // r1 in elements 2 and 4, r0 everywhere else.
    function automatic logic [d_width-1:0] read_value(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? {d_width{1'b1}} : {d_width{1'b0}};
    endfunction

    state_t             state_q;
    logic [2:0]         elem_q;
    logic               last_q;
    logic               gen_reset_q, gen_preset_q, gen_en_q, gen_up_down_q;
    logic               mem_we_q, mem_re_q;
    logic [d_width-1:0] mem_wdata_q;
    logic               busy_q, done_q, fail_q;
    logic [a_width-1:0] fail_addr_q;
    logic [2:0]         fail_elem_q;

    // The carry pulse can arrive in the same cycle as the last op of an
    // element, so the end-of-element decision looks at it directly.
    logic               last_d;
    logic               mismatch_d;
    logic [2:0]         elem_d;

    assign last_d     = last_q | gen_carry_i;
    assign mismatch_d = (mem_rdata_i != read_value(elem_q));
    assign elem_d     = elem_q + 3'd1;

    // Sequencer: state, element index, last-address flag and all outputs.
    // Outputs are registered and loaded together with the state they belong to.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            elem_q        <= 3'd0;
            last_q        <= 1'b0;
            gen_reset_q   <= 1'b0;
            gen_preset_q  <= 1'b0;
            gen_en_q      <= 1'b0;
            gen_up_down_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_wdata_q   <= {d_width{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_addr_q   <= {a_width{1'b0}};
            fail_elem_q   <= 3'd0;
        end else begin
            gen_reset_q  <= 1'b0;
            gen_preset_q <= 1'b0;
            gen_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            if (gen_carry_i) begin
                last_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q       <= S_INIT;
                        elem_q        <= 3'd0;
                        gen_reset_q   <= 1'b1;
                        gen_up_down_q <= 1'b1;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        fail_q        <= 1'b0;
                        fail_addr_q   <= {a_width{1'b0}};
                        fail_elem_q   <= 3'd0;
                    end
                end
                S_INIT, S_NEXT: begin
                    if (state_q == S_INIT) begin
                        last_q <= 1'b0;
                    end
                    if (elem_has_read(elem_q)) begin
                        state_q  <= S_RD;
                        mem_re_q <= 1'b1;
                    end else begin
                        state_q     <= S_WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= write_value(elem_q);
                    end
                end
                S_RD: begin
                    state_q <= S_CHK;
                end
                S_CHK, S_WR: begin
                    if ((state_q == S_CHK) && mismatch_d && !fail_q) begin
                        fail_q      <= 1'b1;
                        fail_addr_q <= gen_address_i;
                        fail_elem_q <= elem_q;
                    end
                    if ((state_q == S_CHK) && mismatch_d && stop_on_fail) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if ((state_q == S_CHK) && elem_has_write(elem_q)) begin
                        state_q     <= S_WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= write_value(elem_q);
                    end else if (last_d) begin
                        if (elem_q == LAST_ELEM) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_INIT;
                            elem_q        <= elem_d;
                            gen_reset_q   <= !elem_desc(elem_d);
                            gen_preset_q  <= elem_desc(elem_d);
                            gen_up_down_q <= !elem_desc(elem_d);
                        end
                    end else begin
                        state_q  <= S_NEXT;
                        gen_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gen_reset_o   = gen_reset_q;
    assign gen_preset_o  = gen_preset_q;
    assign gen_en_o      = gen_en_q;
    assign gen_up_down_o = gen_up_down_q;
    assign mem_we_o      = mem_we_q;
    assign mem_re_o      = mem_re_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fail_o        = fail_q;
    assign fail_addr_o   = fail_addr_q;
    assign fail_elem_o   = fail_elem_q;

endmodule

// File: doc/march_controller.md
Name: march_controller

Overview:
- Sequencing FSM for memory BIST; runs the March C- algorithm over a RAM of 2^a_width words.
- Sits directly upstream of the address generator: drives its reset, preset, en and up_down inputs, and consumes its carry and address outputs.
- Drives memory write/read strobes and write data, compares read data against the expected background, and reports pass/fail with the first failing address and element.

Parameters:
- a_width, 4: address width; must be >= 2; memory depth N = 2^a_width.
- d_width, 8: memory data width.
- stop_on_fail, 0: 1 = enter DONE at the first mismatch; 0 = run all elements, fail flag sticky.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; returns the FSM to IDLE.
- start  in  1  begin a test; sampled only in IDLE.
- gen_reset  out  1  to address generator reset (address forced to 0).
- gen_preset  out  1  to address generator preset (address forced to all ones).
- gen_en  out  1  to address generator en.
- gen_up_down  out  1  to address generator up_down; 1 = ascending.
- gen_carry  in  1  from address generator; one-cycle pulse when the address reaches its end value.
- gen_address  in  a_width  current address from the address generator.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe; synchronous RAM, data valid the next cycle.
- mem_wdata  out  d_width  write data, all zeros or all ones.
- mem_rdata  in  d_width  read data.
- busy  out  1  high from INIT of element 0 until DONE.
- done  out  1  high in DONE; held until start or reset.
- fail  out  1  sticky mismatch flag.
- fail_addr  out  a_width  gen_address at the first mismatch.
- fail_elem  out  3  element index (0-5) of the first mismatch.

Behaviour:
- Reset: state IDLE; all outputs 0, including fail_addr and fail_elem; element index 0; last_flag 0.
- Elements, in order:
  - E0: any order (ascending), w0.
  - E1: ascending, r0, w1.
  - E2: ascending, r1, w0.
  - E3: descending, r0, w1.
  - E4: descending, r1, w0.
  - E5: any order (ascending), r0.
  - w0/w1 write all zeros/all ones. r0/r1 read and expect all zeros/all ones.
- States: IDLE, INIT, RD, CHK, WR, NEXT, DONE.
- IDLE:
  - start=1 -> INIT with element 0.
  - Clear fail, fail_addr and fail_elem; clear done.
- INIT (1 cycle):
  - Ascending element: gen_reset=1. Descending element: gen_preset=1.
  - Clear last_flag. Go to the element's first op.
- WR (1 cycle): mem_we=1; mem_wdata = element's write value.
- RD (1 cycle): mem_re=1.
- CHK (1 cycle, the cycle after RD):
  - Compare mem_rdata with the expected value.
  - On mismatch with fail=0: set fail; capture gen_address into fail_addr and the element index into fail_elem.
  - Later mismatches do not overwrite the capture.
  - Mismatch with stop_on_fail=1 -> DONE.
- gen_address must not change during RD, CHK or WR; gen_en is 0 in those states.
- After the element's last op:
  - last_flag=1: advance to the next element's INIT; after E5 -> DONE.
  - last_flag=0: go to NEXT.
- NEXT (1 cycle): gen_en=1, gen_up_down = element direction. Then the element's first op.
- last_flag: set whenever gen_carry=1; cleared only in INIT. It covers the carry pulse that coincides with the address reaching its end value.
- gen_up_down: held at the current element's direction in all non-IDLE states.
- Cycle count per element: 1 + N*(op cycles per address) + (N-1). A write is 1 cycle; a read is 2.
- DONE:
  - busy=0, done=1, fail/fail_addr/fail_elem held.
  - start=1 -> INIT and a new run; fail cleared on that transition.
- start while busy: ignored.
- reset mid-run: IDLE on the next edge; all outputs 0. The address generator is not forced; the next INIT re-initialises it.
- Only one of gen_reset, gen_preset and gen_en is asserted in any cycle; none in IDLE or DONE.

Test Plan:
- Fault-free RAM model, a_width=2, d_width=8, stop_on_fail=0: pulse start -> busy for exactly 84 cycles (8+16*4+12), then done=1, fail=0.
- Same setup: monitor the address sequence -> E0-E2 visit 0,1,2,3; E3-E4 visit 3,2,1,0; E5 visits 0,1,2,3. Writes are 0x00/0xFF per the element table.
- Stuck-at-0 bit 3 at address 2: full run -> fail=1, fail_addr=2, fail_elem=2 (first r1 is E2; E1 reads 0 correctly). done=1 at cycle 84.
- Same fault with stop_on_fail=1 -> DONE entered the cycle after that CHK; busy falls early; captures identical.
- reset asserted mid-E3 -> next cycle IDLE, all outputs 0. A later start runs the full 84 cycles with fail=0.
- start held high during a run -> no restart. start in DONE with fail=1 -> fail cleared; fresh run completes.
